// File: rtl/vram_scanout_reader.sv
// vram_scanout_reader
//   Reads a completed frame back from DDR2 through MIG port 1 (read-only) and
//   streams 32-bit point words to the display pipeline over valid/ready.
//   Double-buffered: frame_sel, taken with an accepted frame_start, picks the
//   frame region the writer is not currently filling.
// Ports
//   clk0, reset          MIG user clock; asynchronous active-high reset
//   calib_done           MIG calibration done (asynchronous, synchronised here)
//   frame_start/sel      start pulse and buffer select (0: FRAME_BASE0, 1: FRAME_BASE1)
//   p1_cmd_*             read command strobe, instruction, burst length-1, byte address
//   p1_rd_*              first-word-fall-through read FIFO pop, data, empty
//   pix_data/valid/ready point stream, low half of each 64-bit word first
//   pix_sof              marks the first point of a frame
//   frame_done           one-cycle pulse after the last point is accepted
//   overrun              sticky: frame_start seen outside IDLE
module vram_scanout_reader #(
    parameter int unsigned FRAME_BASE0 = 0,
    parameter int unsigned FRAME_BASE1 = 70560,
    parameter int unsigned FRAME_BYTES = 70560,
    parameter int unsigned BURST_WORDS = 16
) (
    input  logic        clk0,
    input  logic        reset,
    input  logic        calib_done,
    input  logic        frame_start,
    input  logic        frame_sel,
    output logic        p1_cmd_en,
    output logic [2:0]  p1_cmd_instr,
    output logic [5:0]  p1_cmd_bl,
    output logic [29:0] p1_cmd_byte_addr,
    input  logic        p1_cmd_full,
    output logic        p1_rd_en,
    input  logic [63:0] p1_rd_data,
    input  logic        p1_rd_empty,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        frame_done,
    output logic        overrun
);
    localparam int unsigned FRAME_WORDS = FRAME_BYTES / 8;
    localparam logic [13:0] C_FRAME_WORDS = 14'(FRAME_WORDS);
    localparam logic [13:0] C_BURST       = 14'(BURST_WORDS);
    localparam logic [29:0] C_BASE0       = 30'(FRAME_BASE0);
    localparam logic [29:0] C_BASE1       = 30'(FRAME_BASE1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_WAIT_CAL,
        S_IDLE,
        S_CMD,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_cal_meta;
    logic        r_cal_sync;
    logic [2:0]  r_empty_cnt;
    logic [29:0] r_addr;
    logic [13:0] r_words_left;
    logic [13:0] r_burst_left;
    logic [63:0] r_hold;
    logic        r_hv;
    logic        r_h;
    logic        r_first;
    logic        r_overrun;

    logic [13:0] w_n;
    logic        w_cmd_fire;
    logic        w_pop;
    logic        w_accept;
    logic        w_burst_done;
    logic        w_flush_done;

    assign w_n          = (r_words_left < C_BURST) ? r_words_left : C_BURST;
    assign w_cmd_fire   = (r_state == S_CMD) && !p1_cmd_full;
    // Pop only into an empty hold register, or while its high half leaves.
    assign w_pop        = (r_state == S_DRAIN) && !p1_rd_empty && (r_burst_left != '0) &&
                          (!r_hv || (r_h && pix_ready));
    assign w_accept     = r_hv && pix_ready;
    assign w_burst_done = (r_state == S_DRAIN) && (r_burst_left == '0) && !r_hv;
    // Fourth consecutive empty cycle: three already counted plus this one.
    assign w_flush_done = p1_rd_empty && (r_empty_cnt == 3'd3);

    // State register
    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) r_state <= S_FLUSH;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FLUSH:    if (w_flush_done) w_next = S_WAIT_CAL;
            S_WAIT_CAL: if (r_cal_sync) w_next = S_IDLE;
            S_IDLE:     if (frame_start) w_next = S_CMD;
            S_CMD:      if (!p1_cmd_full) w_next = S_DRAIN;
            S_DRAIN:    if (w_burst_done) w_next = (r_words_left == '0) ? S_IDLE : S_CMD;
            default:    w_next = S_FLUSH;
        endcase
    end

    // Output logic
    always_comb begin
        p1_cmd_en        = 1'b0;
        p1_cmd_instr     = 3'b001;
        p1_cmd_bl        = '0;
        p1_cmd_byte_addr = '0;
        p1_rd_en         = 1'b0;
        frame_done       = 1'b0;
        case (r_state)
            // Stale words from a burst cut off by reset are discarded here;
            // popping is held off while reset itself is asserted.
            S_FLUSH: p1_rd_en = !p1_rd_empty && !reset;
            S_CMD: begin
                if (!p1_cmd_full) begin
                    p1_cmd_en        = 1'b1;
                    p1_cmd_bl        = 6'(w_n - 14'd1);
                    p1_cmd_byte_addr = r_addr;
                end
            end
            S_DRAIN: begin
                p1_rd_en   = w_pop;
                frame_done = w_burst_done && (r_words_left == '0);
            end
            default: ;
        endcase
    end

    assign pix_valid = r_hv;
    assign pix_data  = r_h ? r_hold[63:32] : r_hold[31:0];
    assign pix_sof   = r_hv && !r_h && r_first;
    assign overrun   = r_overrun;

    // Datapath: calibration sync, flush counter, addressing, hold register
    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            r_cal_meta   <= 1'b0;
            r_cal_sync   <= 1'b0;
            r_empty_cnt  <= '0;
            r_addr       <= '0;
            r_words_left <= '0;
            r_burst_left <= '0;
            r_hold       <= '0;
            r_hv         <= 1'b0;
            r_h          <= 1'b0;
            r_first      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_cal_meta <= calib_done;
            r_cal_sync <= r_cal_meta;

            if (r_state == S_FLUSH)
                r_empty_cnt <= p1_rd_empty ? r_empty_cnt + 3'd1 : '0;

            if (frame_start && (r_state != S_IDLE))
                r_overrun <= 1'b1;

            if ((r_state == S_IDLE) && frame_start) begin
                r_addr       <= frame_sel ? C_BASE1 : C_BASE0;
                r_words_left <= C_FRAME_WORDS;
                r_first      <= 1'b1;
            end

            if (w_cmd_fire) begin
                r_addr       <= r_addr + {13'd0, w_n, 3'd0};
                r_words_left <= r_words_left - w_n;
                r_burst_left <= w_n;
            end

            // A pop in the same cycle as the high half leaving takes priority.
            if (w_pop) begin
                r_hold       <= p1_rd_data;
                r_hv         <= 1'b1;
                r_h          <= 1'b0;
                r_burst_left <= r_burst_left - 14'd1;
            end else if (w_accept) begin
                if (!r_h) r_h  <= 1'b1;
                else      r_hv <= 1'b0;
            end

            if (w_accept && !r_h && r_first)
                r_first <= 1'b0;
        end
    end
endmodule
